// File: rtl/bv_lookup_scheduler.sv
// Lookup-lane scheduler: shares four bit-vector lanes between four requesters and routes the match index back.
// Optional performance counters are enabled with `define BV_SCHED_PERF_CNT_EN.
module bv_lookup_scheduler #(
    parameter int SEG_W      = 16,
    parameter int BIN_W      = 6,
    parameter int LOOKUP_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             cfg_mode_i,
    input  logic                   cfg_req_i,
    output logic                   cfg_ack_o,
    output logic [1:0]             mode_o,
    input  logic [3:0]             req_valid_i,
    output logic [3:0]             req_ready_o,
    input  logic [4*4*SEG_W-1:0]   req_key_i,
    output logic [3:0]             lane_valid_o,
    output logic [4*SEG_W-1:0]     lane_key_o,
    input  logic [4*(2+BIN_W)-1:0] res_i,
    output logic [3:0]             rsp_valid_o,
    output logic [4*BIN_W-1:0]     rsp_idx_o,
    output logic [3:0]             rsp_err_o,
    output logic                   busy_o
`ifdef BV_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]            perf_grant_o,
    output logic [31:0]            perf_stall_o
`endif
);

    localparam int RES_W = 2 + BIN_W;
    localparam int TAIL  = LOOKUP_LAT - 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [1:0] mode_q, mode_d;
    logic [1:0] cfg_mode_q, cfg_mode_d;
    logic [1:0] rr_q, rr_d;
    logic [1:0] eff_mode;
    logic       ack_q, ack_d;
    logic       grant_en;

    logic [3:0][3:0][SEG_W-1:0] key_seg;
    logic [3:0][RES_W-1:0]      res_lane;

    logic [3:0]      grant;
    logic [3:0]      slot_vld;
    logic [3:0][1:0] slot_id;
    logic            found_a, found_b;
    logic [1:0]      id_a, id_b, scan_idx;

    logic [3:0]            lane_vld_q, lane_vld_d;
    logic [3:0][SEG_W-1:0] lane_key_q, lane_key_d;

    // Issue register: tag of the lookups currently presented on the lanes.
    logic [3:0]      iss_vld_q, iss_vld_d;
    logic [3:0][1:0] iss_id_q, iss_id_d;
    logic [1:0]      iss_mode_q, iss_mode_d;

    logic [LOOKUP_LAT-1:0][3:0]      pv_q, pv_d;
    logic [LOOKUP_LAT-1:0][3:0][1:0] pid_q, pid_d;
    logic [LOOKUP_LAT-1:0][1:0]      pm_q, pm_d;

    logic [3:0]            rsp_vld_q, rsp_vld_d;
    logic [3:0]            rsp_err_q, rsp_err_d;
    logic [3:0][BIN_W-1:0] rsp_idx_q, rsp_idx_d;

    assign key_seg  = req_key_i;
    assign res_lane = res_i;
    assign eff_mode = (mode_q == 2'b11) ? 2'b00 : mode_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (cfg_req_i) state_d = ST_DRAIN;
            ST_DRAIN:  if (!busy_o) state_d = ST_SWITCH;
            ST_SWITCH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        grant_en   = (state_q == ST_RUN) && !cfg_req_i;
        ack_d      = (state_q == ST_SWITCH);
        cfg_mode_d = cfg_mode_q;
        mode_d     = mode_q;
        if ((state_q == ST_RUN) && cfg_req_i) cfg_mode_d = cfg_mode_i;
        if (state_q == ST_SWITCH) mode_d = cfg_mode_q;
    end

    // Slot numbering equals the lane whose accumulation result answers that slot.
    always_comb begin
        grant      = '0;
        slot_vld   = '0;
        slot_id    = '0;
        lane_vld_d = '0;
        lane_key_d = '0;
        rr_d       = rr_q;
        found_a    = 1'b0;
        found_b    = 1'b0;
        id_a       = 2'd0;
        id_b       = 2'd0;
        scan_idx   = 2'd0;
        if (grant_en) begin
            case (eff_mode)
                2'b10: begin
                    for (int k = 0; k < 4; k++) begin
                        if (req_valid_i[k]) begin
                            grant[k]      = 1'b1;
                            slot_vld[k]   = 1'b1;
                            slot_id[k]    = 2'(k);
                            lane_vld_d[k] = 1'b1;
                            lane_key_d[k] = key_seg[k][0];
                        end
                    end
                end
                default: begin
                    for (int i = 0; i < 4; i++) begin
                        scan_idx = rr_q + 2'(i);
                        if (req_valid_i[scan_idx]) begin
                            if (!found_a) begin
                                found_a = 1'b1;
                                id_a    = scan_idx;
                            end else if (!found_b) begin
                                found_b = 1'b1;
                                id_b    = scan_idx;
                            end
                        end
                    end
                    if (found_a) begin
                        grant[id_a] = 1'b1;
                        slot_vld[0] = 1'b1;
                        slot_id[0]  = id_a;
                        rr_d        = id_a + 2'd1;
                        if (eff_mode == 2'b00) begin
                            lane_vld_d = 4'hf;
                            lane_key_d = key_seg[id_a];
                        end else begin
                            lane_vld_d[1:0] = 2'b11;
                            lane_key_d[0]   = key_seg[id_a][0];
                            lane_key_d[1]   = key_seg[id_a][1];
                        end
                    end
                    if (found_b && (eff_mode == 2'b01)) begin
                        grant[id_b]     = 1'b1;
                        slot_vld[2]     = 1'b1;
                        slot_id[2]      = id_b;
                        rr_d            = id_b + 2'd1;
                        lane_vld_d[3:2] = 2'b11;
                        lane_key_d[2]   = key_seg[id_b][0];
                        lane_key_d[3]   = key_seg[id_b][1];
                    end
                end
            endcase
        end
    end

    always_comb begin
        iss_vld_d  = slot_vld;
        iss_id_d   = slot_id;
        iss_mode_d = mode_q;
        pv_d[0]    = iss_vld_q;
        pid_d[0]   = iss_id_q;
        pm_d[0]    = iss_mode_q;
        for (int i = 1; i < LOOKUP_LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
            pm_d[i]  = pm_q[i-1];
        end
    end

    // The tail stage lines up with res_i; each valid slot answers its own requester.
    always_comb begin
        rsp_vld_d = '0;
        rsp_idx_d = '0;
        rsp_err_d = '0;
        for (int s = 0; s < 4; s++) begin
            if (pv_q[TAIL][s]) begin
                rsp_vld_d[pid_q[TAIL][s]] = 1'b1;
                rsp_idx_d[pid_q[TAIL][s]] = res_lane[s][BIN_W-1:0];
                rsp_err_d[pid_q[TAIL][s]] = (res_lane[s][RES_W-1:BIN_W] != pm_q[TAIL]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= 2'b00;
            cfg_mode_q <= 2'b00;
            rr_q       <= 2'd0;
            ack_q      <= 1'b0;
            lane_vld_q <= '0;
            lane_key_q <= '0;
            iss_vld_q  <= '0;
            iss_id_q   <= '0;
            iss_mode_q <= '0;
            pv_q       <= '0;
            pid_q      <= '0;
            pm_q       <= '0;
            rsp_vld_q  <= '0;
            rsp_idx_q  <= '0;
            rsp_err_q  <= '0;
        end else begin
            mode_q     <= mode_d;
            cfg_mode_q <= cfg_mode_d;
            rr_q       <= rr_d;
            ack_q      <= ack_d;
            lane_vld_q <= lane_vld_d;
            lane_key_q <= lane_key_d;
            iss_vld_q  <= iss_vld_d;
            iss_id_q   <= iss_id_d;
            iss_mode_q <= iss_mode_d;
            pv_q       <= pv_d;
            pid_q      <= pid_d;
            pm_q       <= pm_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_idx_q  <= rsp_idx_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready_o  = grant;
    assign cfg_ack_o    = ack_q;
    assign mode_o       = mode_q;
    assign lane_valid_o = lane_vld_q;
    assign lane_key_o   = lane_key_q;
    assign rsp_valid_o  = rsp_vld_q;
    assign rsp_idx_o    = rsp_idx_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (|pv_q) | (|iss_vld_q);

`ifdef BV_SCHED_PERF_CNT_EN
    logic [31:0] perf_grant_q, perf_grant_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        if ((|grant) && (perf_grant_q != '1)) perf_grant_d = perf_grant_q + 32'd1;
        if ((|req_valid_i) && !(|grant) && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_o = perf_grant_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
